// File: rtl/gtech_pkg.sv
// Shared constants and elaboration helpers for the GTECH wide-gate reduction primitives.
// MODE[1] picks the base operation (0 AND, 1 OR); MODE[0]=0 inverts the final result.
package gtech_pkg;

   localparam logic [1:0] GT_NAND = 2'b00;
   localparam logic [1:0] GT_AND  = 2'b01;
   localparam logic [1:0] GT_NOR  = 2'b10;
   localparam logic [1:0] GT_OR   = 2'b11;

   function automatic int unsigned gt_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = unsigned'(i) + 1;
      end
      return r;
   endfunction

   // Register stages needed to cover the tree depth, never fewer than one.
   function automatic int unsigned gt_stages(input int unsigned n, input int unsigned lps);
      int unsigned d;
      int unsigned s;
      d = gt_clog2(n);
      s = (d + lps - 1) / lps;
      if (s == 0) s = 1;
      return s;
   endfunction

   // Identity element of the base operation, used to fill unused tree leaves.
   function automatic logic gt_pad_bit(input logic [1:0] mode);
      return ~mode[1];
   endfunction

endpackage

// File: rtl/gtech_red_stage.sv
// One pipeline stage of the reduction tree: up to Levels pairwise-combine levels followed by
// a register holding the partial results, the item's valid bit and its MODE.
module gtech_red_stage
   import gtech_pkg::*;
#(
   parameter int unsigned Width  = 1,
   parameter int unsigned InCnt  = 2,
   parameter int unsigned Levels = 1,
   parameter bit          Last   = 1'b0,
   parameter int unsigned OutCnt = InCnt >> Levels
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     adv_i,
   input  logic                     vld_i,
   input  logic [1:0]               mode_i,
   input  logic [InCnt*Width-1:0]   data_i,
   output logic                     vld_o,
   output logic [1:0]               mode_o,
   output logic [OutCnt*Width-1:0]  data_o
);

   logic [Width-1:0]        tmp [InCnt];
   logic [OutCnt*Width-1:0] res;
   logic                    vld_q;
   logic [1:0]              mode_q;
   logic [OutCnt*Width-1:0] data_q;

   // Combine in place: level l writes slot j from slots 2j and 2j+1, which are never below j.
   always_comb begin
      for (int i = 0; i < int'(InCnt); i++) begin
         tmp[i] = data_i[i*Width +: Width];
      end
      for (int l = 0; l < int'(Levels); l++) begin
         for (int j = 0; j < int'(InCnt >> (l + 1)); j++) begin
            tmp[j] = mode_i[1] ? (tmp[2*j] | tmp[2*j+1]) : (tmp[2*j] & tmp[2*j+1]);
         end
      end
      res = '0;
      for (int i = 0; i < int'(OutCnt); i++) begin
         res[i*Width +: Width] = tmp[i];
      end
      if (Last && !mode_i[0]) res = ~res;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         mode_q <= 2'b00;
         data_q <= '0;
      end else if (adv_i) begin
         vld_q  <= vld_i;
         mode_q <= mode_i;
         data_q <= res;
      end
   end

   assign vld_o  = vld_q;
   assign mode_o = mode_q;
   assign data_o = data_q;

endmodule

// File: rtl/gtech_nand_tree_pipe.sv
// Pipelined N-operand bitwise NAND/AND/NOR/OR reduction with a valid/ready handshake.
// The whole pipe advances together and holds as one block while the output is stalled.
module gtech_nand_tree_pipe
   import gtech_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned LPS   = 1
) (
   input  logic                 CP,
   input  logic                 RST,
   input  logic [N*WIDTH-1:0]   A,
   input  logic [1:0]           MODE,
   input  logic                 IN_VLD,
   output logic                 IN_RDY,
   output logic [WIDTH-1:0]     Z,
   output logic                 OUT_VLD,
   input  logic                 OUT_RDY
);

   localparam int unsigned D = gt_clog2(N);
   localparam int unsigned P = 1 << D;
   localparam int unsigned S = gt_stages(N, LPS);

   logic                 stall;
   logic                 advance;
   logic                 accept;
   logic [P*WIDTH-1:0]   leaves;

   assign stall   = OUT_VLD & ~OUT_RDY;
   assign advance = ~stall;
   assign IN_RDY  = ~RST & ~stall;
   assign accept  = IN_VLD & IN_RDY;

   always_comb begin
      leaves = {(P*WIDTH){gt_pad_bit(MODE)}};
      for (int i = 0; i < int'(N); i++) begin
         leaves[i*WIDTH +: WIDTH] = A[i*WIDTH +: WIDTH];
      end
   end

   for (genvar s = 0; s < int'(S); s++) begin : g_stage
      localparam int unsigned Base   = s * LPS;
      localparam int unsigned Levels = ((D - Base) < LPS) ? (D - Base) : LPS;
      localparam int unsigned InCnt  = 1 << (D - Base);
      localparam int unsigned OutCnt = InCnt >> Levels;

      logic                     vld_in;
      logic [1:0]               mode_in;
      logic [InCnt*WIDTH-1:0]   data_in;
      logic                     vld_out;
      logic [1:0]               mode_out;
      logic [OutCnt*WIDTH-1:0]  data_out;

      if (s == 0) begin : g_head
         assign vld_in  = accept;
         assign mode_in = MODE;
         assign data_in = leaves;
      end else begin : g_body
         assign vld_in  = g_stage[s-1].vld_out;
         assign mode_in = g_stage[s-1].mode_out;
         assign data_in = g_stage[s-1].data_out;
      end

      gtech_red_stage #(
         .Width  (WIDTH),
         .InCnt  (InCnt),
         .Levels (Levels),
         .Last   (s == int'(S) - 1),
         .OutCnt (OutCnt)
      ) u_stage (
         .clk_i  (CP),
         .rst_i  (RST),
         .adv_i  (advance),
         .vld_i  (vld_in),
         .mode_i (mode_in),
         .data_i (data_in),
         .vld_o  (vld_out),
         .mode_o (mode_out),
         .data_o (data_out)
      );
   end

   assign OUT_VLD = g_stage[S-1].vld_out;
   assign Z       = g_stage[S-1].data_out;

endmodule
